regfile_writeback_unit: RTL and testbench
=========================================

Name: regfile_writeback_unit

Overview:
- Writer side of the CPU register file. Accepts ALU results from execute and in-order load responses from data memory.
- Extracts, aligns and sign/zero-extends load data, then drives one registered write per cycle into the register file write port.
- Tracks in-flight loads in a small queue and exports a per-register busy mask to decode for load-use hazard stalls.

Parameters:
- LQ_DEPTH, 4, number of outstanding loads tracked; power of two, minimum 2.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- ex_valid  input  1  execute result valid
- ex_ready  output  1  execute result accepted this cycle
- ex_rd  input  5  destination register of the execute result
- ex_data  input  32  execute result value
- ld_req_valid  input  1  load issued to memory
- ld_req_ready  output  1  load queue can accept an entry
- ld_rd  input  5  load destination register
- ld_funct3  input  3  load type (RV32I encoding)
- ld_addr_lo  input  2  byte offset of the load address
- ld_rsp_valid  input  1  memory load response (cannot be stalled)
- ld_rsp_data  input  32  raw aligned memory word
- wb_write_enable  output  1  register file write enable
- wb_addr_rd  output  5  register file write address
- wb_data_rd  output  32  register file write data
- busy_mask  output  32  bit r set while any queued load targets r
- protocol_err  output  1  sticky: response arrived with queue empty
- misalign_err  output  1  sticky misalignment flag (optional feature)

Behaviour:
- Reset is synchronous and active-high on clock; clock is clock.
- Reset values: queue empty, pointers 0, wb_write_enable 0, wb_addr_rd 0, wb_data_rd 0, protocol_err 0, misalign_err 0, busy_mask 0.
- Reset mid-operation discards all pending entries. Responses arriving afterwards are treated as "queue empty".
- Load queue is a circular FIFO with LQ_DEPTH entries of {rd, funct3, addr_lo}.
  - Push when ld_req_valid && ld_req_ready.
  - Pop when ld_rsp_valid && queue not empty.
  - Pointers wrap modulo LQ_DEPTH. An occupancy counter of width clog2(LQ_DEPTH)+1 sets full and empty.
- ld_req_ready = !full. A push while full is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop in the non-full state leaves occupancy unchanged.
- An ld_rsp_valid with the queue empty pops nothing, writes nothing and sets protocol_err, which holds until reset.
- Write arbitration: exactly one write source per cycle, and a load response has priority.
  - ex_ready = !(ld_rsp_valid && !empty), combinational.
  - An execute result is consumed only on ex_valid && ex_ready.
- Latency: one cycle. Source data accepted in cycle N appears on wb_* in cycle N+1 and holds exactly one cycle.
- wb_write_enable is 0 in any cycle with no accepted source.
- A source with rd == 0 is accepted or popped normally but produces wb_write_enable = 0.
- Load extraction uses the popped entry's funct3 and addr_lo:
  - 000 LB: byte[addr_lo], sign-extended.
  - 100 LBU: byte[addr_lo], zero-extended.
  - 001 LH: halfword[addr_lo[1]], sign-extended.
  - 101 LHU: halfword[addr_lo[1]], zero-extended.
  - 010 LW: full word.
  - Any other funct3: raw word, write still performed.
- busy_mask[r] = OR over valid queue entries of (entry.rd == r), for r != 0. busy_mask[0] is always 0.
  - Combinational from queue contents.
  - Two in-flight loads to the same rd keep the bit set until both have popped.
  - A bit clears in the cycle after its last entry's response.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- Defined:
  - An LH/LHU with addr_lo[0] = 1, or an LW with addr_lo != 0, sets misalign_err at the response pop.
  - That write is suppressed (wb_write_enable = 0) and the entry still pops.
  - misalign_err is sticky until reset.
- Undefined:
  - No check is made; extraction uses the lane selected by addr_lo bits as specified above.
  - misalign_err is tied to 0.

Test Plan:
- Reset, then ex_valid with rd=5, data=0x12345678 -> next cycle wb_write_enable=1, wb_addr_rd=5, wb_data_rd=0x12345678. All outputs were 0 during reset.
- Issue LB rd=3 addr_lo=2, then respond 0x00800000 -> busy_mask=0x8 until the response, then write 0xFFFFFF80 to x3 and busy_mask returns to 0. LBU with the same stimulus writes 0x00000080.
- Issue 4 loads (full, LQ_DEPTH=4) -> ld_req_ready=0, and a fifth request is refused. Responses write x1..x4 in issue order, pointers wrap, and a further push/pop round trip succeeds.
- Same cycle ld_rsp_valid and ex_valid (rd=7) -> ex_ready=0 and the load is written. The ALU result is written one cycle later, once ex_ready=1.
- ld_rsp_valid with the queue empty -> no write, protocol_err=1 held. Separately, an ex result with rd=0 produces no write enable.
- WB_MISALIGN_TRAP_EN defined: LW with addr_lo=1 -> misalign_err=1, no write, and the entry is popped.

Source files
------------

// File: rtl/regfile_writeback_unit.sv
// Register-file writeback: arbitrates ALU results and in-order load responses, tracks in-flight loads.
// Optional misaligned-load trap enabled by defining WB_MISALIGN_TRAP_EN.
module regfile_writeback_unit #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_rsp_valid,
  input  logic [31:0] ld_rsp_data,
  output logic        wb_write_enable,
  output logic [4:0]  wb_addr_rd,
  output logic [31:0] wb_data_rd,
  output logic [31:0] busy_mask,
  output logic        protocol_err,
  output logic        misalign_err
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } lq_entry_t;

  lq_entry_t            r_lq [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]  r_lq_valid;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_protocol_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ex_acc;
  logic                 w_misalign;
  lq_entry_t            w_head;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_ld_value;
  logic [31:0]          w_busy;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = ld_req_valid && !w_full;
  assign w_pop    = ld_rsp_valid && !w_empty;
  assign w_ex_acc = ex_valid && ex_ready;

  assign ld_req_ready = !w_full;
  assign ex_ready     = !w_pop;
  assign protocol_err = r_protocol_err;

  // NOTE: queue payload is deliberately not reset; r_lq_valid and r_count alone say what is live.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_lq[r_wr_ptr] <= '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lq_valid     <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_lq_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_lq_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (ld_rsp_valid && w_empty) r_protocol_err <= 1'b1;
    end
  end

  assign w_head = r_lq[r_rd_ptr];
  assign w_byte = ld_rsp_data[{w_head.addr_lo, 3'b000} +: 8];
  assign w_half = w_head.addr_lo[1] ? ld_rsp_data[31:16] : ld_rsp_data[15:0];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_ld_value = ld_rsp_data;
    case (w_head.funct3)
      3'b000:  w_ld_value = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_value = {24'h0, w_byte};
      3'b001:  w_ld_value = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_value = {16'h0, w_half};
      default: w_ld_value = ld_rsp_data;
    endcase
  end

`ifdef WB_MISALIGN_TRAP_EN
  logic r_misalign_err;

  assign w_misalign = w_pop &&
      ((((w_head.funct3 == 3'b001) || (w_head.funct3 == 3'b101)) && w_head.addr_lo[0]) ||
       ((w_head.funct3 == 3'b010) && (w_head.addr_lo != 2'b00)));

  always_ff @(posedge clock) begin
    if (reset)           r_misalign_err <= 1'b0;
    else if (w_misalign) r_misalign_err <= 1'b1;
  end

  assign misalign_err = r_misalign_err;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Load responses win the single write port; address/data hold between writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_write_enable <= 1'b0;
      wb_addr_rd      <= '0;
      wb_data_rd      <= '0;
    end else if (w_pop) begin
      wb_write_enable <= (w_head.rd != 5'd0) && !w_misalign;
      wb_addr_rd      <= w_head.rd;
      wb_data_rd      <= w_ld_value;
    end else if (w_ex_acc) begin
      wb_write_enable <= (ex_rd != 5'd0);
      wb_addr_rd      <= ex_rd;
      wb_data_rd      <= ex_data;
    end else begin
      wb_write_enable <= 1'b0;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (r_lq_valid[i]) w_busy[r_lq[i].rd] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  assign busy_mask = w_busy;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit: directed cases plus randomized traffic
// against a queue-based behavioural model.
module tb_regfile_writeback_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic        wb_write_enable;
  logic [4:0]  wb_addr_rd;
  logic [31:0] wb_data_rd;
  logic [31:0] busy_mask;
  logic        protocol_err;
  logic        misalign_err;

  regfile_writeback_unit #(.LQ_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .wb_write_enable(wb_write_enable), .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd),
    .busy_mask(busy_mask), .protocol_err(protocol_err), .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ld_t;

  ld_t         q[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_perr;
  logic        exp_mis;
  logic        exp_zero;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic model_misaligned(input ld_t e);
`ifdef WB_MISALIGN_TRAP_EN
    if ((e.f3 == 3'd1 || e.f3 == 3'd5) && (e.lo % 2 == 1)) return 1'b1;
    if (e.f3 == 3'd2 && e.lo != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = 0;
    foreach (q[i]) m = m | (32'd1 << q[i].rd);
    return m & ~32'd1;
  endfunction

  // One clock cycle: check combinational outputs against the model, advance the model,
  // then check the registered outputs just after the edge.
  task automatic step();
    int sz;
    ld_t e;
    #1;
    sz = q.size();
    check("ex_ready", ex_ready, !(ld_rsp_valid && sz > 0));
    check("ld_req_ready", ld_req_ready, sz < DEPTH);
    check("busy_mask", busy_mask, model_busy());
    exp_zero = 1'b0;
    if (reset) begin
      q.delete();
      exp_we = 0; exp_perr = 0; exp_mis = 0; exp_zero = 1'b1;
    end else begin
      exp_we = 0;
      if (ld_rsp_valid && sz > 0) begin
        e = q.pop_front();
        exp_addr = e.rd;
        exp_data = model_load(ld_rsp_data, e.f3, e.lo);
        exp_we   = (e.rd != 0) && !model_misaligned(e);
        if (model_misaligned(e)) exp_mis = 1'b1;
      end else begin
        if (ld_rsp_valid) exp_perr = 1'b1;
        if (ex_valid) begin
          exp_we   = (ex_rd != 0);
          exp_addr = ex_rd;
          exp_data = ex_data;
        end
      end
      if (ld_req_valid && sz < DEPTH) begin
        e.rd = ld_rd; e.f3 = ld_funct3; e.lo = ld_addr_lo;
        q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    check("wb_write_enable", wb_write_enable, exp_we);
    check("protocol_err", protocol_err, exp_perr);
    check("misalign_err", misalign_err, exp_mis);
    if (exp_we || exp_zero) begin
      check("wb_addr_rd", wb_addr_rd, exp_zero ? 5'd0 : exp_addr);
      check("wb_data_rd", wb_data_rd, exp_zero ? 32'd0 : exp_data);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_req_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    ld_rsp_valid = 0; ld_rsp_data = 0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    idle_inputs();
    ld_req_valid = 1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo;
    step();
  endtask

  task automatic respond(input logic [31:0] data);
    idle_inputs();
    ld_rsp_valid = 1; ld_rsp_data = data;
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clock);
    #1;
    exp_we = 0; exp_perr = 0; exp_mis = 0; exp_zero = 1'b1;
    step();
    check("reset wb_we", wb_write_enable, 32'd0);
    check("reset wb_data", wb_data_rd, 32'd0);
    check("reset busy", busy_mask, 32'd0);

    // ALU result to x5
    idle_inputs();
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'h1234_5678;
    step();
    check("alu we lit", wb_write_enable, 32'd1);
    check("alu addr lit", wb_addr_rd, 32'd5);
    check("alu data lit", wb_data_rd, 32'h1234_5678);
    idle_inputs();
    step();
    check("alu one-cycle lit", wb_write_enable, 32'd0);

    // LB / LBU to x3, byte lane 2
    issue_load(5'd3, 3'd0, 2'd2);
    check("lb busy lit", busy_mask, 32'h8);
    idle_inputs();
    step();
    check("lb busy hold lit", busy_mask, 32'h8);
    respond(32'h0080_0000);
    check("lb data lit", wb_data_rd, 32'hFFFF_FF80);
    check("lb busy clear lit", busy_mask, 32'h0);
    issue_load(5'd3, 3'd4, 2'd2);
    respond(32'h0080_0000);
    check("lbu data lit", wb_data_rd, 32'h0000_0080);
    check("model lh lit", model_load(32'h8001_0000, 3'd1, 2'd2), 32'hFFFF_8001);

    // Fill the queue, refuse a fifth, drain in order
    for (int i = 1; i <= 4; i++) issue_load(5'(i), 3'd2, 2'd0);
    check("full ready lit", ld_req_ready, 32'd0);
    check("full busy lit", busy_mask, 32'h1E);
    issue_load(5'd9, 3'd2, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      respond(32'hA000_0000 + 32'(i));
      check("drain addr lit", wb_addr_rd, 32'(i));
    end
    issue_load(5'd10, 3'd5, 2'd3);
    respond(32'hBEEF_0000);
    check("wrap lhu lit", wb_data_rd, 32'h0000_BEEF);

    // Response and ALU collide: load first, ALU next cycle
    issue_load(5'd6, 3'd2, 2'd0);
    idle_inputs();
    ld_rsp_valid = 1; ld_rsp_data = 32'hCAFE_F00D;
    ex_valid = 1; ex_rd = 5'd7; ex_data = 32'h7777_0007;
    step();
    check("collide addr lit", wb_addr_rd, 32'd6);
    ld_rsp_valid = 0;
    step();
    check("alu after collide lit", wb_addr_rd, 32'd7);

    // ALU write to x0 is suppressed; response on empty queue flags protocol_err
    idle_inputs();
    ex_valid = 1; ex_rd = 5'd0; ex_data = 32'hFFFF_FFFF;
    step();
    check("x0 we lit", wb_write_enable, 32'd0);
    respond(32'h1111_1111);
    check("perr lit", protocol_err, 32'd1);
    idle_inputs();
    step();
    check("perr sticky lit", protocol_err, 32'd1);

`ifdef WB_MISALIGN_TRAP_EN
    issue_load(5'd12, 3'd2, 2'd1);
    respond(32'h1234_5678);
    check("misalign lit", misalign_err, 32'd1);
    check("misalign busy lit", busy_mask, 32'd0);
`endif

    // Reset with loads pending discards them
    issue_load(5'd8, 3'd2, 2'd0);
    issue_load(5'd9, 3'd2, 2'd0);
    idle_inputs();
    reset = 1;
    step();
    check("mid-reset busy lit", busy_mask, 32'd0);
    respond(32'h2222_2222);
    check("post-reset perr lit", protocol_err, 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      ex_valid     = $urandom_range(0, 1);
      ex_rd        = 5'($urandom_range(0, 31));
      ex_data      = $urandom;
      ld_req_valid = ($urandom_range(0, 9) < 5);
      ld_rd        = 5'($urandom_range(0, 7));
      ld_funct3    = 3'($urandom_range(0, 7));
      ld_addr_lo   = 2'($urandom_range(0, 3));
      ld_rsp_valid = ($urandom_range(0, 9) < 4);
      ld_rsp_data  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
